// File: rtl/pc8001_bus_pkg.sv
// Shared definitions for the PC-8001 main-RAM bus arbiter: owner mux encoding
// and the arbiter state enum.
package pc8001_bus_pkg;

  localparam logic [1:0] OWN_CPU  = 2'b00;
  localparam logic [1:0] OWN_CRTC = 2'b01;
  localparam logic [1:0] OWN_EXT  = 2'b10;
  localparam logic [1:0] OWN_NONE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CRTC,
    ST_EXT,
    ST_HANDOVER,
    ST_REL
  } arb_state_t;

endpackage

// File: rtl/ram_bus_arbiter.sv
// Main-RAM bus arbiter: takes the bus from the Z80 via BUSREQ/BUSAK and grants it
// to the CRTC row fetch (absolute priority) or the rate-limited aux DMA requester.
module ram_bus_arbiter
  import pc8001_bus_pkg::*;
#(
  parameter int EXT_MAX    = 64,
  parameter int CPU_MIN    = 16,
  parameter int LATE_LIMIT = 200,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       crtc_busreq,
  output logic       crtc_busack,
  input  logic       ext_busreq,
  output logic       ext_busack,
  output logic       cpu_busreq_n,
  input  logic       cpu_busak_n,
  output logic [1:0] ram_owner,
  output logic       crtc_late,
  input  logic       late_clr
);

  // Handshake: a master owns the bus exactly while its busack is high; busack
  // rises only after the Z80 has answered BUSREQ with BUSAK, and drops the cycle
  // after the master's request level is seen low (or on preemption/limit).

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(EXT_MAX - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(CPU_MIN);
  localparam logic [CNT_W-1:0] LATE_MAX  = CNT_W'(LATE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] hold_q, gap_q, wait_q;
  logic             busreq_n_d, crtc_ack_d, ext_ack_d;
  logic [1:0]       owner_d;
  logic             waiting, late_hit;

  // State register; outputs are registered from the decode of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cpu_busreq_n <= 1'b1;
      crtc_busack  <= 1'b0;
      ext_busack   <= 1'b0;
      ram_owner    <= OWN_CPU;
    end else begin
      state_q      <= state_d;
      cpu_busreq_n <= busreq_n_d;
      crtc_busack  <= crtc_ack_d;
      ext_busack   <= ext_ack_d;
      ram_owner    <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (crtc_busreq)                         state_d = ST_REQ;
        else if (ext_busreq && gap_q == '0)      state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!cpu_busak_n) begin
          if (crtc_busreq)     state_d = ST_CRTC;
          else if (ext_busreq) state_d = ST_EXT;
          else                 state_d = ST_REL;
        end
      end
      ST_CRTC: begin
        if (!crtc_busreq) state_d = ST_REL;
      end
      ST_EXT: begin
        if (crtc_busreq)                            state_d = ST_HANDOVER;
        else if (!ext_busreq || hold_q == HOLD_LAST) state_d = ST_REL;
      end
      ST_HANDOVER: state_d = ST_CRTC;
      ST_REL: begin
        if (cpu_busak_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busreq_n_d = 1'b1;
    crtc_ack_d = 1'b0;
    ext_ack_d  = 1'b0;
    owner_d    = OWN_CPU;
    unique case (state_d)
      ST_IDLE:     ;
      ST_REQ:      busreq_n_d = 1'b0;
      ST_CRTC: begin
        busreq_n_d = 1'b0;
        crtc_ack_d = 1'b1;
        owner_d    = OWN_CRTC;
      end
      ST_EXT: begin
        busreq_n_d = 1'b0;
        ext_ack_d  = 1'b1;
        owner_d    = OWN_EXT;
      end
      ST_HANDOVER: begin
        busreq_n_d = 1'b0;
        owner_d    = OWN_NONE;
      end
      ST_REL:      owner_d = OWN_NONE;
      default:     ;
    endcase
  end

  // Hold counts cycles of the current aux grant; gap enforces CPU time after a release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      gap_q  <= '0;
    end else begin
      if (state_q != ST_EXT) hold_q <= '0;
      else                   hold_q <= hold_q + 1'b1;

      if (state_q == ST_REL && state_d == ST_IDLE)  gap_q <= GAP_LOAD;
      else if (state_q == ST_IDLE && gap_q != '0)   gap_q <= gap_q - 1'b1;
    end
  end

  assign waiting  = crtc_busreq && !crtc_busack;
  assign late_hit = waiting && (wait_q >= LATE_MAX - 1'b1);

  // Late flag is sticky; a coincident set beats late_clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= '0;
      crtc_late <= 1'b0;
    end else begin
      if (!waiting)              wait_q <= '0;
      else if (wait_q != LATE_MAX) wait_q <= wait_q + 1'b1;

      if (late_hit)      crtc_late <= 1'b1;
      else if (late_clr) crtc_late <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: directed scenarios with exact timing
// plus a randomized run checked against rule-level bus properties.
module tb_ram_bus_arbiter;

  localparam int EXT_MAX    = 64;
  localparam int CPU_MIN    = 16;
  localparam int LATE_LIMIT = 200;
  localparam int CNT_W      = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       crtc_busreq = 1'b0;
  logic       ext_busreq = 1'b0;
  logic       cpu_busak_n = 1'b1;
  logic       late_clr = 1'b0;
  logic       crtc_busack, ext_busack, cpu_busreq_n, crtc_late;
  logic [1:0] ram_owner;

  int total = 0;
  int bad = 0;

  // Z80 BUSAK model: BUSAK follows BUSREQ after lat cycles unless forced high
  logic [7:0] hist = 8'hFF;
  int         lat = 3;
  bit         busak_force = 1'b0;

  ram_bus_arbiter #(
    .EXT_MAX(EXT_MAX), .CPU_MIN(CPU_MIN), .LATE_LIMIT(LATE_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .crtc_busreq(crtc_busreq), .crtc_busack(crtc_busack),
    .ext_busreq(ext_busreq), .ext_busack(ext_busack),
    .cpu_busreq_n(cpu_busreq_n), .cpu_busak_n(cpu_busak_n),
    .ram_owner(ram_owner), .crtc_late(crtc_late), .late_clr(late_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    hist = {hist[6:0], cpu_busreq_n};
    cpu_busak_n = busak_force ? 1'b1 : hist[lat-1];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(ram_owner == 2'b00 && cpu_busreq_n === 1'b1) && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL %s idle timeout: owner=%b busreq_n=%b want owner=00 busreq_n=1",
               tag, ram_owner, cpu_busreq_n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++;
    if (cpu_busreq_n !== 1'b1 || crtc_busack !== 1'b0 || ext_busack !== 1'b0) begin
      bad++;
      $display("FAIL reset handshake: busreq_n=%b crtc_ack=%b ext_ack=%b want 1 0 0",
               cpu_busreq_n, crtc_busack, ext_busack);
    end
    total++;
    if (ram_owner !== 2'b00 || crtc_late !== 1'b0) begin
      bad++;
      $display("FAIL reset owner/late: owner=%b late=%b want 00 0", ram_owner, crtc_late);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    total++;
    if (ram_owner !== 2'b00 || cpu_busreq_n !== 1'b1) begin
      bad++;
      $display("FAIL post-reset idle: owner=%b busreq_n=%b want 00 1", ram_owner, cpu_busreq_n);
    end
  endtask

  task automatic test_crtc_grant();
    int n = 0;
    repeat (4) tick();
    crtc_busreq = 1'b1;
    tick();
    total++;
    if (cpu_busreq_n !== 1'b0 || ram_owner !== 2'b00 || crtc_busack !== 1'b0) begin
      bad++;
      $display("FAIL crtc request latency: busreq_n=%b owner=%b ack=%b want 0 00 0",
               cpu_busreq_n, ram_owner, crtc_busack);
    end
    while (crtc_busack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL crtc grant latency: cycles=%0d want 3", n);
    end
    total++;
    if (ram_owner !== 2'b01) begin
      bad++;
      $display("FAIL crtc owner: owner=%b want 01", ram_owner);
    end
    crtc_busreq = 1'b0;
    tick();
    total++;
    if (crtc_busack !== 1'b0 || cpu_busreq_n !== 1'b1 || ram_owner !== 2'b11) begin
      bad++;
      $display("FAIL crtc release: ack=%b busreq_n=%b owner=%b want 0 1 11",
               crtc_busack, cpu_busreq_n, ram_owner);
    end
    wait_idle("crtc_grant");
  endtask

  task automatic test_ext_forced();
    int n = 0;
    int run = 0;
    int gapc = 0;
    repeat (CPU_MIN + 4) tick();
    ext_busreq = 1'b1;
    while (ext_busack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL ext grant timeout: ack=%b want 1", ext_busack);
    end
    while (ext_busack === 1'b1 && run < 200) begin
      tick();
      run++;
    end
    total++;
    if (run != EXT_MAX) begin
      bad++;
      $display("FAIL ext forced release length: cycles=%0d want %0d", run, EXT_MAX);
    end
    n = 0;
    while (ram_owner != 2'b00 && n < 20) begin
      tick();
      n++;
    end
    while (ram_owner == 2'b00 && cpu_busreq_n === 1'b1 && gapc < 200) begin
      tick();
      gapc++;
    end
    total++;
    if (gapc < CPU_MIN || gapc > CPU_MIN + 1) begin
      bad++;
      $display("FAIL ext cpu gap: idle cycles=%0d want %0d..%0d", gapc, CPU_MIN, CPU_MIN + 1);
    end
    n = 0;
    while (ext_busack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL ext regrant timeout: ack=%b want 1", ext_busack);
    end
    ext_busreq = 1'b0;
    wait_idle("ext_forced");
  endtask

  task automatic test_preempt();
    int n = 0;
    repeat (CPU_MIN + 4) tick();
    ext_busreq = 1'b1;
    while (ext_busack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    repeat (2) tick();
    crtc_busreq = 1'b1;
    tick();
    total++;
    if (ext_busack !== 1'b0 || crtc_busack !== 1'b0 || ram_owner !== 2'b11 || cpu_busreq_n !== 1'b0) begin
      bad++;
      $display("FAIL preempt handover: ext=%b crtc=%b owner=%b busreq_n=%b want 0 0 11 0",
               ext_busack, crtc_busack, ram_owner, cpu_busreq_n);
    end
    tick();
    total++;
    if (crtc_busack !== 1'b1 || ram_owner !== 2'b01 || cpu_busreq_n !== 1'b0) begin
      bad++;
      $display("FAIL preempt crtc grant: crtc=%b owner=%b busreq_n=%b want 1 01 0",
               crtc_busack, ram_owner, cpu_busreq_n);
    end
    crtc_busreq = 1'b0;
    ext_busreq = 1'b0;
    tick();
    wait_idle("preempt");
  endtask

  task automatic test_simultaneous();
    int n = 0;
    int gapc = 0;
    repeat (CPU_MIN + 4) tick();
    crtc_busreq = 1'b1;
    ext_busreq = 1'b1;
    while (crtc_busack !== 1'b1 && ext_busack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (crtc_busack !== 1'b1 || ext_busack !== 1'b0) begin
      bad++;
      $display("FAIL simultaneous first grant: crtc=%b ext=%b want 1 0", crtc_busack, ext_busack);
    end
    crtc_busreq = 1'b0;
    tick();
    n = 0;
    while (!(ram_owner == 2'b00 && cpu_busreq_n === 1'b1) && n < 20) begin
      tick();
      n++;
    end
    while (ram_owner == 2'b00 && cpu_busreq_n === 1'b1 && gapc < 200) begin
      tick();
      gapc++;
    end
    total++;
    if (gapc < CPU_MIN) begin
      bad++;
      $display("FAIL simultaneous gap before ext: idle cycles=%0d want >=%0d", gapc, CPU_MIN);
    end
    n = 0;
    while (ext_busack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (ext_busack !== 1'b1 || ram_owner !== 2'b10) begin
      bad++;
      $display("FAIL simultaneous ext grant: ext=%b owner=%b want 1 10", ext_busack, ram_owner);
    end
    ext_busreq = 1'b0;
    wait_idle("simultaneous");
  endtask

  task automatic test_late();
    repeat (4) tick();
    busak_force = 1'b1;
    crtc_busreq = 1'b1;
    repeat (150) tick();
    total++;
    if (crtc_late !== 1'b0) begin
      bad++;
      $display("FAIL late early: late=%b want 0 after 150 cycles", crtc_late);
    end
    repeat (60) tick();
    total++;
    if (crtc_late !== 1'b1) begin
      bad++;
      $display("FAIL late set: late=%b want 1 after 210 cycles", crtc_late);
    end
    late_clr = 1'b1;
    tick();
    late_clr = 1'b0;
    total++;
    if (crtc_late !== 1'b1) begin
      bad++;
      $display("FAIL late set-wins: late=%b want 1", crtc_late);
    end
    crtc_busreq = 1'b0;
    busak_force = 1'b0;
    wait_idle("late");
    tick();
    total++;
    if (crtc_late !== 1'b1) begin
      bad++;
      $display("FAIL late sticky: late=%b want 1", crtc_late);
    end
    late_clr = 1'b1;
    tick();
    late_clr = 1'b0;
    total++;
    if (crtc_late !== 1'b0) begin
      bad++;
      $display("FAIL late clear: late=%b want 0", crtc_late);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    repeat (4) tick();
    crtc_busreq = 1'b1;
    while (crtc_busack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (cpu_busreq_n !== 1'b1 || crtc_busack !== 1'b0 || ext_busack !== 1'b0 || ram_owner !== 2'b00) begin
      bad++;
      $display("FAIL async reset mid-grant: busreq_n=%b crtc=%b ext=%b owner=%b want 1 0 0 00",
               cpu_busreq_n, crtc_busack, ext_busack, ram_owner);
    end
    crtc_busreq = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    total++;
    if (cpu_busreq_n !== 1'b1 || ram_owner !== 2'b00 || crtc_busack !== 1'b0) begin
      bad++;
      $display("FAIL idle after reset: busreq_n=%b owner=%b crtc=%b want 1 00 0",
               cpu_busreq_n, ram_owner, crtc_busack);
    end
  endtask

  // Random traffic checked against arbitration rules rather than cycle timing
  task automatic test_random();
    int  ext_run = 0;
    int  idle_cnt = CPU_MIN;
    int  crtc_wait = 0;
    bit  prev_ext = 1'b0;
    lat = $urandom_range(1, 4);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      total++;
      if (crtc_busack !== (ram_owner == 2'b01) || ext_busack !== (ram_owner == 2'b10)) begin
        bad++;
        $display("FAIL rnd owner/ack cycle %0d: owner=%b crtc=%b ext=%b", cyc, ram_owner, crtc_busack, ext_busack);
      end
      total++;
      if ((crtc_busack || ext_busack) && (cpu_busreq_n !== 1'b0 || cpu_busak_n !== 1'b0)) begin
        bad++;
        $display("FAIL rnd grant without bus cycle %0d: busreq_n=%b busak_n=%b want 0 0", cyc, cpu_busreq_n, cpu_busak_n);
      end
      ext_run = ext_busack ? ext_run + 1 : 0;
      total++;
      if (ext_run > EXT_MAX) begin
        bad++;
        $display("FAIL rnd ext hold cycle %0d: run=%0d want <=%0d", cyc, ext_run, EXT_MAX);
      end
      if (ext_busack && !prev_ext) begin
        total++;
        if (idle_cnt < CPU_MIN) begin
          bad++;
          $display("FAIL rnd ext gap cycle %0d: idle=%0d want >=%0d", cyc, idle_cnt, CPU_MIN);
        end
      end
      prev_ext = ext_busack;
      if (crtc_busack || ext_busack || ram_owner == 2'b11) idle_cnt = 0;
      else if (ram_owner == 2'b00 && cpu_busreq_n === 1'b1) idle_cnt++;
      crtc_wait = (crtc_busreq && !crtc_busack) ? crtc_wait + 1 : 0;
      total++;
      if (crtc_wait > 24) begin
        bad++;
        $display("FAIL rnd crtc wait cycle %0d: waited=%0d want <=24", cyc, crtc_wait);
      end
      if (crtc_busreq) begin
        if (crtc_busack && $urandom_range(0, 15) == 0) crtc_busreq = 1'b0;
      end else if ($urandom_range(0, 39) == 0) crtc_busreq = 1'b1;
      if (ext_busreq) begin
        if ($urandom_range(0, 99) == 0) ext_busreq = 1'b0;
      end else if ($urandom_range(0, 9) == 0) ext_busreq = 1'b1;
    end
    crtc_busreq = 1'b0;
    ext_busreq = 1'b0;
    wait_idle("random");
    total++;
    if (crtc_late !== 1'b0) begin
      bad++;
      $display("FAIL rnd late flag: late=%b want 0", crtc_late);
    end
  endtask

  initial begin
    test_reset();
    test_crtc_grant();
    test_ext_forced();
    test_preempt();
    test_simultaneous();
    test_late();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
